// File: rtl/powlib_sfifo_if.sv
// Handshake bundle for powlib_sfifo: write end, read end and fill status.
interface powlib_sfifo_if #(
  parameter int W = 32,
  parameter int D = 8
);
  localparam int WIDX = $clog2(D);

  logic [W-1:0]  wrdata;
  logic          wrvld;
  logic          wrrdy;
  logic [W-1:0]  rddata;
  logic          rdvld;
  logic          rdrdy;
  logic [WIDX:0] cnt;
  logic          afull;

  // Producer/consumer side of the FIFO
  modport master (
    output wrdata, wrvld, rdrdy,
    input  wrrdy, rddata, rdvld, cnt, afull
  );

  // FIFO side
  modport slave (
    input  wrdata, wrvld, rdrdy,
    output wrrdy, rddata, rdvld, cnt, afull
  );
endinterface

// File: rtl/powlib_sfifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both ends.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate flag; the head word is read combinationally.
module powlib_sfifo #(
  parameter int W    = 32,
  parameter int D    = 8,
  parameter int WIDX = $clog2(D),
  parameter int AFT  = D - 2
) (
  input  logic           clk,
  input  logic           rst,
  powlib_sfifo_if.slave  fifo
);

  localparam logic [WIDX:0] PTR_ONE = (WIDX + 1)'(1);
  localparam logic [WIDX:0] AFT_L   = (WIDX + 1)'(AFT);

  logic [W-1:0]  mem_q [D];
  logic [WIDX:0] wrptr_q, wrptr_d;
  logic [WIDX:0] rdptr_q, rdptr_d;
  logic [WIDX:0] cnt_q, cnt_d;
  logic          full;
  logic          empty;
  logic          wr_acc;
  logic          rd_acc;

  // Status decode, handshake acceptance and next pointer/count values
  always_comb begin
    empty   = (wrptr_q == rdptr_q);
    full    = (wrptr_q[WIDX] != rdptr_q[WIDX]) &&
              (wrptr_q[WIDX-1:0] == rdptr_q[WIDX-1:0]);
    wr_acc  = fifo.wrvld && !full;
    rd_acc  = fifo.rdrdy && !empty;
    wrptr_d = wr_acc ? (wrptr_q + PTR_ONE) : wrptr_q;
    rdptr_d = rd_acc ? (rdptr_q + PTR_ONE) : rdptr_q;
    cnt_d   = wrptr_d - rdptr_d;
  end

  // Pointer and count state; reset empties the FIFO without an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      cnt_q   <= '0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage write; contents are never cleared, rdvld masks stale words
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wrptr_q[WIDX-1:0]] <= fifo.wrdata;
    end
  end

  assign fifo.wrrdy  = !full;
  assign fifo.rdvld  = !empty;
  assign fifo.rddata = mem_q[rdptr_q[WIDX-1:0]];
  assign fifo.cnt    = cnt_q;
  assign fifo.afull  = (cnt_q >= AFT_L);

endmodule

// File: tb/tb_powlib_sfifo.sv
// Directed and randomised bench for powlib_sfifo (W=32, D=8, AFT=6).
module tb_powlib_sfifo;

  localparam int W   = 32;
  localparam int D   = 8;
  localparam int AFT = 6;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W-1:0] mq [$];

  powlib_sfifo_if #(.W(W), .D(D)) bus ();

  powlib_sfifo #(.W(W), .D(D), .AFT(AFT)) dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge with the reference queue following the accepted handshakes.
  // Inputs are driven and outputs sampled at the falling edge.
  task automatic cycle();
    bit wacc;
    bit racc;
    wacc = bus.wrvld && (mq.size() < D);
    racc = bus.rdrdy && (mq.size() != 0);
    @(posedge clk);
    if (racc) void'(mq.pop_front());
    if (wacc) mq.push_back(bus.wrdata);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.wrvld = 1'b1; bus.wrdata = 32'hDEAD_BEEF; bus.rdrdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rdvld !== 1'b0) begin errors++; $display("FAIL reset_rdvld got %0h exp 0", bus.rdvld); end
    checks++; if (bus.wrrdy !== 1'b1) begin errors++; $display("FAIL reset_wrrdy got %0h exp 1", bus.wrrdy); end
    checks++; if (bus.cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.cnt); end
    checks++; if (bus.afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %0h exp 0", bus.afull); end
    rst = 1'b1;
    mq.delete();
    bus.wrdata = 32'h11;
    checks++; if (bus.rdvld !== 1'b0) begin errors++; $display("FAIL nobypass_rdvld got %0h exp 0", bus.rdvld); end
    cycle();
    bus.wrvld = 1'b0;
    checks++; if (bus.rdvld !== 1'b1) begin errors++; $display("FAIL first_rdvld got %0h exp 1", bus.rdvld); end
    checks++; if (bus.rddata !== 32'h11) begin errors++; $display("FAIL first_rddata got %0h exp 11", bus.rddata); end
    checks++; if (bus.cnt !== 4'd1) begin errors++; $display("FAIL first_cnt got %0d exp 1", bus.cnt); end
    bus.rdrdy = 1'b1;
    cycle();
    bus.rdrdy = 1'b0;
    checks++; if (bus.rdvld !== 1'b0) begin errors++; $display("FAIL first_drain got %0h exp 0", bus.rdvld); end
  endtask

  task automatic test_fill();
    bus.rdrdy = 1'b0;
    bus.wrvld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.wrdata = 32'(i);
      cycle();
      checks++; if (bus.cnt !== 4'(i + 1)) begin errors++; $display("FAIL fill_cnt got %0d exp %0d", bus.cnt, i + 1); end
      checks++; if (bus.afull !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_afull got %0h exp %0h at cnt %0d", bus.afull, (i + 1 >= 6), i + 1); end
    end
    checks++; if (bus.wrrdy !== 1'b0) begin errors++; $display("FAIL full_wrrdy got %0h exp 0", bus.wrrdy); end
    bus.wrdata = 32'hFF;
    cycle();
    bus.wrvld = 1'b0;
    checks++; if (bus.cnt !== 4'd8) begin errors++; $display("FAIL overflow_cnt got %0d exp 8", bus.cnt); end
    bus.rdrdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.rdvld !== 1'b1 || bus.rddata !== 32'(i)) begin errors++; $display("FAIL drain_data got %0h/%0h exp 1/%0h", bus.rdvld, bus.rddata, i); end
      cycle();
    end
    bus.rdrdy = 1'b0;
    checks++; if (bus.rdvld !== 1'b0 || bus.cnt !== 4'd0) begin errors++; $display("FAIL drain_empty got %0h/%0d exp 0/0", bus.rdvld, bus.cnt); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    bus.rdrdy = 1'b0;
    bus.wrvld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wrdata = 32'h200 + 32'(i);
      cycle();
    end
    bus.rdrdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      exp = (k < 4) ? 32'h200 + 32'(k) : 32'h100 + 32'(k - 4);
      bus.wrdata = 32'h100 + 32'(k);
      checks++; if (bus.rddata !== exp) begin errors++; $display("FAIL b2b_data got %0h exp %0h", bus.rddata, exp); end
      cycle();
      checks++; if (bus.cnt !== 4'd4) begin errors++; $display("FAIL b2b_cnt got %0d exp 4", bus.cnt); end
    end
    bus.wrvld = 1'b0;
    for (int k = 16; k < 20; k++) begin
      checks++; if (bus.rddata !== 32'h100 + 32'(k)) begin errors++; $display("FAIL b2b_tail got %0h exp %0h", bus.rddata, 32'h100 + k); end
      cycle();
    end
    bus.rdrdy = 1'b0;
    checks++; if (bus.rdvld !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0h exp 0", bus.rdvld); end
  endtask

  task automatic test_full_contention();
    bus.rdrdy = 1'b0;
    bus.wrvld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.wrdata = 32'h300 + 32'(i);
      cycle();
    end
    bus.wrdata = 32'h3AA;
    bus.rdrdy = 1'b1;
    checks++; if (bus.wrrdy !== 1'b0) begin errors++; $display("FAIL fc_wrrdy got %0h exp 0", bus.wrrdy); end
    cycle();
    checks++; if (bus.cnt !== 4'd7 || bus.rddata !== 32'h301) begin errors++; $display("FAIL fc_edge1 got %0d/%0h exp 7/301", bus.cnt, bus.rddata); end
    checks++; if (bus.wrrdy !== 1'b1) begin errors++; $display("FAIL fc_wrrdy2 got %0h exp 1", bus.wrrdy); end
    cycle();
    bus.wrvld = 1'b0;
    checks++; if (bus.cnt !== 4'd7 || bus.rddata !== 32'h302) begin errors++; $display("FAIL fc_edge2 got %0d/%0h exp 7/302", bus.cnt, bus.rddata); end
    for (int i = 2; i < 9; i++) begin
      checks++; if (bus.rddata !== ((i < 8) ? 32'h300 + 32'(i) : 32'h3AA)) begin errors++; $display("FAIL fc_drain got %0h at %0d", bus.rddata, i); end
      cycle();
    end
    bus.rdrdy = 1'b0;
    checks++; if (bus.rdvld !== 1'b0) begin errors++; $display("FAIL fc_empty got %0h exp 0", bus.rdvld); end
  endtask

  task automatic test_empty_contention();
    bus.wrvld = 1'b1;
    bus.rdrdy = 1'b1;
    bus.wrdata = 32'hA5;
    checks++; if (bus.rdvld !== 1'b0) begin errors++; $display("FAIL ec_rdvld0 got %0h exp 0", bus.rdvld); end
    cycle();
    bus.wrvld = 1'b0;
    checks++; if (bus.cnt !== 4'd1 || bus.rddata !== 32'hA5 || bus.rdvld !== 1'b1) begin errors++; $display("FAIL ec_edge1 got %0d/%0h exp 1/a5", bus.cnt, bus.rddata); end
    cycle();
    bus.rdrdy = 1'b0;
    checks++; if (bus.cnt !== 4'd0 || bus.rdvld !== 1'b0) begin errors++; $display("FAIL ec_edge2 got %0d/%0h exp 0/0", bus.cnt, bus.rdvld); end
  endtask

  task automatic test_async_reset();
    bus.wrvld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wrdata = 32'h500 + 32'(i);
      cycle();
    end
    bus.wrvld = 1'b0;
    checks++; if (bus.cnt !== 4'd5) begin errors++; $display("FAIL ar_pre_cnt got %0d exp 5", bus.cnt); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.rdvld !== 1'b0 || bus.cnt !== 4'd0) begin errors++; $display("FAIL ar_immediate got %0h/%0d exp 0/0", bus.rdvld, bus.cnt); end
    checks++; if (bus.wrrdy !== 1'b1 || bus.afull !== 1'b0) begin errors++; $display("FAIL ar_flags got %0h/%0h exp 1/0", bus.wrrdy, bus.afull); end
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    bus.wrvld = 1'b1;
    bus.wrdata = 32'h3C;
    cycle();
    bus.wrdata = 32'h3D;
    cycle();
    bus.wrvld = 1'b0;
    checks++; if (bus.rddata !== 32'h3C || bus.cnt !== 4'd2) begin errors++; $display("FAIL ar_newdata got %0h/%0d exp 3c/2", bus.rddata, bus.cnt); end
    bus.rdrdy = 1'b1;
    cycle();
    cycle();
    bus.rdrdy = 1'b0;
  endtask

  task automatic test_random();
    bus.wrvld = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if (!(bus.wrvld && mq.size() == D)) begin
        bus.wrvld  = 1'($urandom_range(0, 1));
        bus.wrdata = $urandom;
      end
      bus.rdrdy = ($urandom_range(0, 2) != 0);
      checks++; if (bus.rdvld !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_rdvld got %0h exp %0h", bus.rdvld, mq.size() != 0); end
      checks++; if (bus.wrrdy !== (mq.size() != D)) begin errors++; $display("FAIL rnd_wrrdy got %0h exp %0h", bus.wrrdy, mq.size() != D); end
      checks++; if (bus.cnt !== 4'(mq.size())) begin errors++; $display("FAIL rnd_cnt got %0d exp %0d", bus.cnt, mq.size()); end
      checks++; if (bus.afull !== (mq.size() >= AFT)) begin errors++; $display("FAIL rnd_afull got %0h exp %0h", bus.afull, mq.size() >= AFT); end
      if (mq.size() != 0) begin
        checks++; if (bus.rddata !== mq[0]) begin errors++; $display("FAIL rnd_data got %0h exp %0h", bus.rddata, mq[0]); end
      end
      cycle();
    end
    bus.wrvld = 1'b0;
    bus.rdrdy = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.wrvld = 1'b0;
    bus.rdrdy = 1'b0;
    bus.wrdata = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_back_to_back();
    test_full_contention();
    test_empty_contention();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
